// File: rtl/id_exe_reg_if.sv
// ID/EXE pipeline-register bus.
// Carries the ID-stage payload and control (id_*), the MEM-stage destination
// feedback (mem_*), the pipeline controls (freeze, flush, has_forwarding),
// and the registered EXE-stage payload (exe_*) plus the hazard request.
//   master : ID/control side  - drives id_*, mem_*, controls; reads exe_*, hazard
//   slave  : pipeline register - reads id_*, mem_*, controls; drives exe_*, hazard
interface id_exe_reg_if #(
  parameter int unsigned W = 32
);
  logic         freeze;
  logic         flush;
  logic         has_forwarding;

  logic [W-1:0] id_pc;
  logic [W-1:0] id_val1;
  logic [W-1:0] id_val2;
  logic [W-1:0] id_ST_val;
  logic [4:0]   id_src1;
  logic [4:0]   id_src2;
  logic [4:0]   id_ST_src;
  logic [4:0]   id_dest;
  logic [3:0]   id_EXE_CMD;
  logic         id_MEM_R_en;
  logic         id_MEM_W_en;
  logic         id_WB_en;
  logic         id_imm;

  logic [4:0]   mem_dest;
  logic         mem_WB_en;

  logic [W-1:0] exe_pc;
  logic [W-1:0] exe_val1;
  logic [W-1:0] exe_val2;
  logic [W-1:0] exe_ST_val;
  logic [4:0]   exe_src1;
  logic [4:0]   exe_src2;
  logic [4:0]   exe_ST_src;
  logic [4:0]   exe_dest;
  logic [3:0]   exe_EXE_CMD;
  logic         exe_MEM_R_en;
  logic         exe_MEM_W_en;
  logic         exe_WB_en;
  logic         exe_imm;
  logic         exe_valid;

  logic         hazard;

  modport master (
    output freeze, flush, has_forwarding,
    output id_pc, id_val1, id_val2, id_ST_val,
    output id_src1, id_src2, id_ST_src, id_dest,
    output id_EXE_CMD, id_MEM_R_en, id_MEM_W_en, id_WB_en, id_imm,
    output mem_dest, mem_WB_en,
    input  exe_pc, exe_val1, exe_val2, exe_ST_val,
    input  exe_src1, exe_src2, exe_ST_src, exe_dest,
    input  exe_EXE_CMD, exe_MEM_R_en, exe_MEM_W_en, exe_WB_en, exe_imm, exe_valid,
    input  hazard
  );

  modport slave (
    input  freeze, flush, has_forwarding,
    input  id_pc, id_val1, id_val2, id_ST_val,
    input  id_src1, id_src2, id_ST_src, id_dest,
    input  id_EXE_CMD, id_MEM_R_en, id_MEM_W_en, id_WB_en, id_imm,
    input  mem_dest, mem_WB_en,
    output exe_pc, exe_val1, exe_val2, exe_ST_val,
    output exe_src1, exe_src2, exe_ST_src, exe_dest,
    output exe_EXE_CMD, exe_MEM_R_en, exe_MEM_W_en, exe_WB_en, exe_imm, exe_valid,
    output hazard
  );
endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with hazard detection.
// Latches the decoded instruction one cycle after ID, inserts bubbles on
// flush or on a data hazard, holds on freeze, and raises a combinational
// hazard request so IF/ID can stall.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - id_exe_reg_if.slave (id_*, mem_*, controls in; exe_*, hazard out)
//   bubble_cnt / flush_cnt - 16-bit saturating bubble counters, present only
//                            when ID_EXE_PERF_CNT_EN is defined
module id_exe_reg #(
  parameter int unsigned W = 32
) (
  input  logic              clk,
  input  logic              rst,
  id_exe_reg_if.slave       bus
`ifdef ID_EXE_PERF_CNT_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // True when a nonzero register index is read by the ID instruction.
  function automatic logic reads_reg(
    input logic [4:0] r,
    input logic [4:0] s1,
    input logic [4:0] s2,
    input logic [4:0] st,
    input logic       use_s2,
    input logic       use_st
  );
    return (r != 5'd0) &&
           ((r == s1) || (use_s2 && (r == s2)) || (use_st && (r == st)));
  endfunction

  logic use_src2;
  logic use_st;
  logic hit_exe;
  logic hit_mem;
  logic raw_hazard;
  logic do_bubble;
  logic do_load;

  // Hazard detection: load-use only with forwarding, any pending write without.
  always_comb begin
    use_src2   = !bus.id_imm || bus.id_MEM_W_en;
    use_st     = bus.id_MEM_W_en;
    hit_exe    = reads_reg(bus.exe_dest, bus.id_src1, bus.id_src2, bus.id_ST_src,
                           use_src2, use_st);
    hit_mem    = reads_reg(bus.mem_dest, bus.id_src1, bus.id_src2, bus.id_ST_src,
                           use_src2, use_st);
    raw_hazard = 1'b0;
    if (bus.has_forwarding) begin
      raw_hazard = bus.exe_valid && bus.exe_MEM_R_en && hit_exe;
    end else begin
      raw_hazard = (bus.exe_valid && bus.exe_WB_en && hit_exe) ||
                   (bus.mem_WB_en && hit_mem);
    end
    // A flushed ID instruction is discarded, so it never stalls.
    bus.hazard = raw_hazard && !bus.flush;
  end

  // Update select: flush beats freeze; freeze beats hazard.
  always_comb begin
    do_bubble = bus.flush || (bus.hazard && !bus.freeze);
    do_load   = !bus.flush && !bus.freeze && !bus.hazard;
  end

  // Stage register; reset and bubble both clear the whole stage.
  always_ff @(posedge clk) begin
    if (rst || do_bubble) begin
      bus.exe_pc       <= W'(0);
      bus.exe_val1     <= W'(0);
      bus.exe_val2     <= W'(0);
      bus.exe_ST_val   <= W'(0);
      bus.exe_src1     <= 5'd0;
      bus.exe_src2     <= 5'd0;
      bus.exe_ST_src   <= 5'd0;
      bus.exe_dest     <= 5'd0;
      bus.exe_EXE_CMD  <= 4'd0;
      bus.exe_MEM_R_en <= 1'b0;
      bus.exe_MEM_W_en <= 1'b0;
      bus.exe_WB_en    <= 1'b0;
      bus.exe_imm      <= 1'b0;
      bus.exe_valid    <= 1'b0;
    end else if (do_load) begin
      bus.exe_pc       <= bus.id_pc;
      bus.exe_val1     <= bus.id_val1;
      bus.exe_val2     <= bus.id_val2;
      bus.exe_ST_val   <= bus.id_ST_val;
      bus.exe_src1     <= bus.id_src1;
      bus.exe_src2     <= bus.id_src2;
      bus.exe_ST_src   <= bus.id_ST_src;
      bus.exe_dest     <= bus.id_dest;
      bus.exe_EXE_CMD  <= bus.id_EXE_CMD;
      bus.exe_MEM_R_en <= bus.id_MEM_R_en;
      bus.exe_MEM_W_en <= bus.id_MEM_W_en;
      bus.exe_WB_en    <= bus.id_WB_en;
      bus.exe_imm      <= bus.id_imm;
      bus.exe_valid    <= 1'b1;
    end
  end

`ifdef ID_EXE_PERF_CNT_EN
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating bubble counters; hazard bubbles suppressed by freeze are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= CNT_W'(0);
      flush_cnt  <= CNT_W'(0);
    end else begin
      if (bus.flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (bus.hazard && !bus.freeze && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: table of per-cycle vectors with the
// expected hazard level and the expected next stage contents (load, bubble,
// hold, reset), expected stage pushed to a scoreboard queue at drive time and
// popped after the clock edge. Counter checks compile with ID_EXE_PERF_CNT_EN.
module tb_id_exe_reg;

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {K_LOAD, K_BUB, K_HOLD, K_ZERO} kind_t;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] val1;
    logic [W-1:0] val2;
    logic [W-1:0] st_val;
    logic [4:0]   src1;
    logic [4:0]   src2;
    logic [4:0]   st_src;
    logic [4:0]   dest;
    logic [3:0]   cmd;
    logic         mr;
    logic         mw;
    logic         wb;
    logic         imm;
    logic         valid;
  } stage_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       flush;
    logic       freeze;
    logic       fwd;
    stage_t     id;
    logic [4:0] mem_dest;
    logic       mem_wb;
    logic       exp_hz;
    kind_t      kind;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_exe_reg_if #(.W(W)) bus ();

`ifdef ID_EXE_PERF_CNT_EN
  logic [15:0] bubble_cnt;
  logic [15:0] flush_cnt;
  id_exe_reg #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus),
                           .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));
`else
  id_exe_reg #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int     n_checks = 0;
  int     n_fail   = 0;
  vec_t   vecs[$];
  stage_t sb[$];
  stage_t exp_cur;
  int     exp_bcnt = 0;
  int     exp_fcnt = 0;

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic r, input logic fl,
                              input logic fz, input logic fw, input logic [31:0] pc,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] st, input logic [4:0] d,
                              input logic mr, input logic mw, input logic wb,
                              input logic imm, input logic [4:0] md, input logic mwb,
                              input logic hz, input kind_t k);
    vec_t v;
    v.name = nm; v.rst = r; v.flush = fl; v.freeze = fz; v.fwd = fw;
    v.id.pc = pc; v.id.val1 = pc ^ 32'hA5A5_0000; v.id.val2 = pc + 32'd7;
    v.id.st_val = ~pc; v.id.src1 = s1; v.id.src2 = s2; v.id.st_src = st;
    v.id.dest = d; v.id.cmd = pc[7:4]; v.id.mr = mr; v.id.mw = mw; v.id.wb = wb;
    v.id.imm = imm; v.id.valid = 1'b0;
    v.mem_dest = md; v.mem_wb = mwb; v.exp_hz = hz; v.kind = k;
    return v;
  endfunction

  function automatic stage_t dut_stage();
    stage_t s;
    s.pc = bus.exe_pc; s.val1 = bus.exe_val1; s.val2 = bus.exe_val2;
    s.st_val = bus.exe_ST_val; s.src1 = bus.exe_src1; s.src2 = bus.exe_src2;
    s.st_src = bus.exe_ST_src; s.dest = bus.exe_dest; s.cmd = bus.exe_EXE_CMD;
    s.mr = bus.exe_MEM_R_en; s.mw = bus.exe_MEM_W_en; s.wb = bus.exe_WB_en;
    s.imm = bus.exe_imm; s.valid = bus.exe_valid;
    return s;
  endfunction

  task automatic drive(input vec_t v);
    rst                = v.rst;
    bus.flush          = v.flush;
    bus.freeze         = v.freeze;
    bus.has_forwarding = v.fwd;
    bus.id_pc          = v.id.pc;
    bus.id_val1        = v.id.val1;
    bus.id_val2        = v.id.val2;
    bus.id_ST_val      = v.id.st_val;
    bus.id_src1        = v.id.src1;
    bus.id_src2        = v.id.src2;
    bus.id_ST_src      = v.id.st_src;
    bus.id_dest        = v.id.dest;
    bus.id_EXE_CMD     = v.id.cmd;
    bus.id_MEM_R_en    = v.id.mr;
    bus.id_MEM_W_en    = v.id.mw;
    bus.id_WB_en       = v.id.wb;
    bus.id_imm         = v.id.imm;
    bus.mem_dest       = v.mem_dest;
    bus.mem_WB_en      = v.mem_wb;
  endtask

  initial begin
    //           name              rst fl fz fw pc      s1 s2 st d   mr mw wb im md mwb hz kind
    vecs.push_back(mk("reset",          1,0,0,1, 32'h100, 5, 5, 5, 5, 1,1,1,1, 5,1, 0, K_ZERO));
    vecs.push_back(mk("load_ld",        0,0,0,1, 32'h010, 1, 2, 0, 5, 1,0,1,0, 0,0, 0, K_LOAD));
    vecs.push_back(mk("load_use",       0,0,0,1, 32'h020, 5, 3, 0, 6, 0,0,1,0, 0,0, 1, K_BUB));
    vecs.push_back(mk("load_use_retry", 0,0,0,1, 32'h020, 5, 3, 0, 6, 0,0,1,0, 0,0, 0, K_LOAD));
    vecs.push_back(mk("fwd_alu_ok",     0,0,0,1, 32'h030, 6, 0, 0, 7, 0,0,1,0, 0,0, 0, K_LOAD));
    vecs.push_back(mk("nofwd_exe",      0,0,0,0, 32'h038, 1, 7, 0, 9, 0,0,1,0, 7,1, 1, K_BUB));
    vecs.push_back(mk("nofwd_mem",      0,0,0,0, 32'h038, 1, 7, 0, 9, 0,0,1,0, 7,1, 1, K_BUB));
    vecs.push_back(mk("nofwd_imm",      0,0,0,0, 32'h040, 1, 7, 0, 0, 1,0,1,1, 7,1, 0, K_LOAD));
    vecs.push_back(mk("zero_idx",       0,0,0,0, 32'h050, 0, 0, 0, 8, 1,0,1,0, 0,1, 0, K_LOAD));
    vecs.push_back(mk("flush_vs_haz",   0,1,0,1, 32'h058, 2, 8, 0, 9, 0,1,0,1, 0,0, 0, K_BUB));
    vecs.push_back(mk("load2",          0,0,0,1, 32'h060, 1, 2, 0,10, 1,0,1,0, 0,0, 0, K_LOAD));
    vecs.push_back(mk("freeze_haz",     0,0,1,1, 32'h068, 3, 4,10, 0, 0,1,0,1, 0,0, 1, K_HOLD));
    vecs.push_back(mk("freeze2",        0,0,1,1, 32'h070,11, 0, 0, 1, 0,0,1,0, 0,0, 0, K_HOLD));
    vecs.push_back(mk("freeze3",        0,0,1,1, 32'h078,12,13, 0, 2, 1,0,1,0, 0,0, 0, K_HOLD));
    vecs.push_back(mk("freeze_flush",   0,1,1,1, 32'h080, 1, 2, 0, 3, 0,0,1,0, 0,0, 0, K_BUB));
    vecs.push_back(mk("load3",          0,0,0,1, 32'h090, 1, 2, 0,12, 1,0,1,0, 0,0, 0, K_LOAD));
    vecs.push_back(mk("rst_mid_freeze", 1,0,1,1, 32'h098, 3, 4, 0, 5, 0,0,1,0, 0,0, 0, K_ZERO));
    vecs.push_back(mk("post_rst_mem",   0,0,0,0, 32'h0A0, 4, 0, 0, 6, 0,0,1,0, 4,1, 1, K_BUB));
    vecs.push_back(mk("load4",          0,0,0,0, 32'h0A8, 1, 2, 0,13, 0,0,1,0, 0,0, 0, K_LOAD));
    vecs.push_back(mk("st_unused",      0,0,0,0, 32'h0B0, 1, 2,13, 3, 0,0,1,1, 0,0, 0, K_LOAD));
    vecs.push_back(mk("st_used_nofwd",  0,0,0,0, 32'h0B8, 1, 2, 3, 4, 0,1,0,1, 0,0, 1, K_BUB));

    // Bring the stage to a known empty state before the table starts.
    drive(vecs[0]);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_cur = '0;

    foreach (vecs[i]) begin
      stage_t nxt;
      drive(vecs[i]);
      #3;
      check({vecs[i].name, "_hazard"}, 256'(bus.hazard), 256'(vecs[i].exp_hz));
      case (vecs[i].kind)
        K_LOAD:  begin nxt = vecs[i].id; nxt.valid = 1'b1; end
        K_HOLD:  nxt = exp_cur;
        default: nxt = '0;
      endcase
      sb.push_back(nxt);
      if (vecs[i].rst) begin
        exp_bcnt = 0; exp_fcnt = 0;
      end else if (vecs[i].kind == K_BUB) begin
        if (vecs[i].flush) exp_fcnt++;
        else               exp_bcnt++;
      end
      @(posedge clk);
      #1;
      exp_cur = sb.pop_front();
      check({vecs[i].name, "_stage"}, 256'(dut_stage()), 256'(exp_cur));
`ifdef ID_EXE_PERF_CNT_EN
      check({vecs[i].name, "_bubble_cnt"}, 256'(bubble_cnt), 256'(exp_bcnt));
      check({vecs[i].name, "_flush_cnt"},  256'(flush_cnt),  256'(exp_fcnt));
`endif
    end

`ifdef ID_EXE_PERF_CNT_EN
    // Persistent MEM-feedback hazard: one bubble every cycle until saturation.
    drive(mk("sat", 0,0,0,0, 32'h0C0, 3, 0, 0, 1, 0,0,1,1, 3,1, 1, K_BUB));
    repeat (65537) @(posedge clk);
    #1;
    check("sat_bubble_cnt", 256'(bubble_cnt), 256'(16'hFFFF));
    check("sat_flush_cnt",  256'(flush_cnt),  256'(exp_fcnt));
    check("sat_valid",      256'(bus.exe_valid), 256'(1'b0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
